// File: rtl/pla_id_seq_gen.sv
// ---------------------------------------------------------------------------
// pla_id_seq_gen
//
// Transmit-side slice-ID sequence generator for the PLA forward path. It emits
// framed slices that carry a monotonically incrementing 15-bit slice ID and a
// 32-bit payload. Beat 0 of every slice holds the single 0x55D5 marker. The
// ID-sequence checker on the far side of a loopback consumes these slices.
//
// Optional feature (compile-time macro PLA_ID_SEQ_ERR_INJ_EN):
//   When defined, an I_err_inj pulse arms a pending flag. The next end of
//   slice then advances the ID by 2 instead of 1, which produces exactly one
//   lost slice at the checker. When not defined, I_err_inj is ignored and no
//   flag is built.
//
// Parameters:
//   SLICE_LEN  beats per slice (2..255)
//   GAP_LEN    idle cycles between slices (1..15)
//
// Ports:
//   I_pla_312m5_clk      system clock
//   I_pla_rst            asynchronous, active-high reset
//   I_gen_start          level enable; slices run back-to-back while high
//   I_pla_tx_ready       downstream ready, sampled only at slice start
//   I_id_load            preset the next slice ID (honoured in IDLE only)
//   I_id_load_val        value for I_id_load
//   I_cnt_clear          synchronous clear of O_slice_tx_cnt
//   I_err_inj            request one ID skip (feature macro only)
//   O_pla_slice_id       ID of the current slice, 0 when no slice is active
//   O_pla_slice_payload  beat payload, 0 when no slice is active
//   O_pla_slice_en       high on every beat of a slice
//   O_slice_sop          high on beat 0
//   O_slice_eop          high on beat SLICE_LEN-1
//   O_slice_tx_cnt       completed slices, wraps at 0xFFFF
//   O_gen_busy           high while in SLICE or GAP
//   O_dbg_state          current FSM state (0 IDLE, 1 SLICE, 2 GAP)
//
// Handshake: I_gen_start && I_pla_tx_ready is evaluated only when a slice
// could begin (in IDLE, or on the last GAP cycle). Once a slice has started
// it always runs to completion whatever either input does.
// ---------------------------------------------------------------------------
module pla_id_seq_gen #(
    parameter int SLICE_LEN = 16,
    parameter int GAP_LEN   = 2
) (
    input  logic        I_pla_312m5_clk,
    input  logic        I_pla_rst,
    input  logic        I_gen_start,
    input  logic        I_pla_tx_ready,
    input  logic        I_id_load,
    input  logic [14:0] I_id_load_val,
    input  logic        I_cnt_clear,
    input  logic        I_err_inj,
    output logic [14:0] O_pla_slice_id,
    output logic [31:0] O_pla_slice_payload,
    output logic        O_pla_slice_en,
    output logic        O_slice_sop,
    output logic        O_slice_eop,
    output logic [15:0] O_slice_tx_cnt,
    output logic        O_gen_busy,
    output logic [1:0]  O_dbg_state
);

    localparam logic [7:0] SLICE_LAST = 8'(SLICE_LEN - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLICE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_beat;
    logic [7:0]  w_beat_nxt;
    logic [3:0]  r_gap;
    logic [3:0]  w_gap_nxt;
    logic [14:0] r_next_id;
    logic [14:0] r_slice_id;
    logic [31:0] r_payload;
    logic        r_en;
    logic        r_sop;
    logic        r_eop;
    logic [15:0] r_tx_cnt;
    logic        r_busy;

    logic        w_go;
    logic        w_eop_now;
    logic        w_sop_nxt;
    logic [14:0] w_id_eff;
    logic [14:0] w_id_step;

    assign w_go      = I_gen_start & I_pla_tx_ready;
    // The beat currently on the bus is the last one of the slice.
    assign w_eop_now = (r_state == ST_SLICE) && (r_beat == SLICE_LAST);
    // Entering beat 0 can only happen from IDLE or GAP.
    assign w_sop_nxt = (w_state_nxt == ST_SLICE) && (r_state != ST_SLICE);
    // A load in the same cycle as the IDLE->SLICE transition tags that slice.
    assign w_id_eff  = ((r_state == ST_IDLE) && I_id_load) ? I_id_load_val : r_next_id;

`ifdef PLA_ID_SEQ_ERR_INJ_EN
    logic r_err_pend;

    always_ff @(posedge I_pla_312m5_clk or posedge I_pla_rst) begin
        if (I_pla_rst) begin
            r_err_pend <= 1'b0;
        end else if (w_eop_now) begin
            // The pending skip is consumed here; a pulse landing on this same
            // eop while already pending is absorbed, otherwise it arms the flag.
            r_err_pend <= ~r_err_pend & I_err_inj;
        end else begin
            r_err_pend <= r_err_pend | I_err_inj;
        end
    end

    assign w_id_step = r_err_pend ? 15'd2 : 15'd1;
`else
    logic w_unused_err_inj;
    assign w_unused_err_inj = I_err_inj;
    assign w_id_step        = 15'd1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_gap_nxt   = r_gap;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_state_nxt = ST_SLICE;
                    w_beat_nxt  = 8'd0;
                end
            end
            ST_SLICE: begin
                if (r_beat == SLICE_LAST) begin
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = 4'd0;
                end else begin
                    w_beat_nxt = r_beat + 8'd1;
                end
            end
            ST_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_nxt = w_go ? ST_SLICE : ST_IDLE;
                    w_beat_nxt  = 8'd0;
                end else begin
                    w_gap_nxt = r_gap + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_pla_312m5_clk or posedge I_pla_rst) begin
        if (I_pla_rst) begin
            r_state    <= ST_IDLE;
            r_beat     <= 8'd0;
            r_gap      <= 4'd0;
            r_next_id  <= 15'd0;
            r_slice_id <= 15'd0;
            r_payload  <= 32'd0;
            r_en       <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_tx_cnt   <= 16'd0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_gap   <= w_gap_nxt;

            if (r_state == ST_IDLE) begin
                r_next_id <= w_id_eff;
            end else if (w_eop_now) begin
                r_next_id <= r_next_id + w_id_step;
            end

            // Outputs are registered from the next state, so they describe
            // the beat that will be on the bus during the following cycle.
            r_en   <= (w_state_nxt == ST_SLICE);
            r_sop  <= w_sop_nxt;
            r_eop  <= (w_state_nxt == ST_SLICE) && (w_beat_nxt == SLICE_LAST);
            r_busy <= (w_state_nxt != ST_IDLE);

            if (w_sop_nxt) begin
                r_slice_id <= w_id_eff;
                r_payload  <= {1'b1, w_id_eff, 16'h55D5};
            end else if (w_state_nxt == ST_SLICE) begin
                r_payload  <= {8'hA5, w_beat_nxt, 1'b1, r_slice_id};
            end else begin
                r_slice_id <= 15'd0;
                r_payload  <= 32'd0;
            end

            if (I_cnt_clear) begin
                r_tx_cnt <= 16'd0;
            end else if (w_eop_now) begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end
        end
    end

    assign O_pla_slice_id      = r_slice_id;
    assign O_pla_slice_payload = r_payload;
    assign O_pla_slice_en      = r_en;
    assign O_slice_sop         = r_sop;
    assign O_slice_eop         = r_eop;
    assign O_slice_tx_cnt      = r_tx_cnt;
    assign O_gen_busy          = r_busy;
    assign O_dbg_state         = r_state;

endmodule

// File: tb/tb_pla_id_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_pla_id_seq_gen
//
// Randomized bench for pla_id_seq_gen. The slice sequence that the stimulus
// implies (IDs, beat payloads, framing, completed-slice count) is pushed into
// an expected queue when each run is issued. An independent monitor pops one
// entry per beat on the bus. Directed checks cover reset, start latency,
// slice period, ID wrap, count clear at eop, error injection and reset in the
// middle of a slice.
// ---------------------------------------------------------------------------
module tb_pla_id_seq_gen;

    localparam int SLICE_LEN = 16;
    localparam int GAP_LEN   = 2;
    localparam int PERIOD    = SLICE_LEN + GAP_LEN;
`ifdef PLA_ID_SEQ_ERR_INJ_EN
    localparam bit ERR_INJ_ON = 1'b1;
`else
    localparam bit ERR_INJ_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic        id_load = 1'b0;
    logic [14:0] id_load_val = 15'd0;
    logic        cnt_clear = 1'b0;
    logic        err_inj = 1'b0;

    logic [14:0] o_id;
    logic [31:0] o_payload;
    logic        o_en;
    logic        o_sop;
    logic        o_eop;
    logic [15:0] o_tx_cnt;
    logic        o_busy;
    logic [1:0]  o_dbg_state;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pla_id_seq_gen #(.SLICE_LEN(SLICE_LEN), .GAP_LEN(GAP_LEN)) dut (
        .I_pla_312m5_clk     (clk),
        .I_pla_rst           (rst),
        .I_gen_start         (start),
        .I_pla_tx_ready      (ready),
        .I_id_load           (id_load),
        .I_id_load_val       (id_load_val),
        .I_cnt_clear         (cnt_clear),
        .I_err_inj           (err_inj),
        .O_pla_slice_id      (o_id),
        .O_pla_slice_payload (o_payload),
        .O_pla_slice_en      (o_en),
        .O_slice_sop         (o_sop),
        .O_slice_eop         (o_eop),
        .O_slice_tx_cnt      (o_tx_cnt),
        .O_gen_busy          (o_busy),
        .O_dbg_state         (o_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [48:0] exp_q[$];      // {sop, eop, id[14:0], payload[31:0]}
    logic [14:0] m_next_id = 15'd0;
    logic [15:0] m_cnt = 16'd0;
    logic [31:0] cap0 = 32'd0;
    logic [31:0] cap1 = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired (got nothing, expected a DUT event)", name);
    endtask

    // Beat k of a slice with the given ID, straight from the slice format.
    function automatic logic [48:0] beat_word(input logic [14:0] id, input int k);
        logic [31:0] pl;
        logic [7:0]  kb;
        kb = 8'(k);
        if (k == 0) pl = {1'b1, id, 16'h55D5};
        else        pl = {8'hA5, kb, 1'b1, id};
        return {(k == 0), (k == SLICE_LEN - 1), id, pl};
    endfunction

    task automatic push_slice(input logic [14:0] id, input int nbeats);
        for (int k = 0; k < nbeats; k++) exp_q.push_back(beat_word(id, k));
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [48:0] exp_w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (o_en) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got id 0x%0h payload 0x%0h, expected no beat",
                                 o_id, o_payload);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("beat", {15'd0, o_sop, o_eop, o_id, o_payload}, {15'd0, exp_w});
                    end
                end else begin
                    check("idle_bus_zero", {o_sop, o_eop, o_id, o_payload}, 49'd0);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Runs n back-to-back slices from IDLE. Optional: ID load on the start
    // cycle, count clear on the first eop, a ready/id_load glitch inside each
    // slice (ignored by the DUT) and an error-inject pulse in the first slice.
    task automatic run_slices(input int n, input bit do_load, input logic [14:0] lval,
                              input bit clr_eop, input int glitch_beat, input bit inj0);
        int          waited;
        int          beat;
        int          k;
        bit          ok;
        bit          eff_inj;
        int unsigned last_sop;

        eff_inj = inj0 && (glitch_beat != 0);
        if (do_load) m_next_id = lval;
        for (int s = 0; s < n; s++) begin
            push_slice(m_next_id, SLICE_LEN);
            m_next_id = m_next_id + ((eff_inj && s == 0 && ERR_INJ_ON) ? 15'd2 : 15'd1);
            m_cnt     = (clr_eop && s == 0) ? 16'd0 : m_cnt + 16'd1;
        end

        start = 1'b1;
        ready = 1'b1;
        id_load = do_load;
        id_load_val = lval;
        last_sop = 0;
        for (int s = 0; s < n; s++) begin
            waited = 0;
            ok = 1'b0;
            while (waited < 4 * PERIOD && !ok) begin
                @(negedge clk);
                waited++;
                if (o_sop) ok = 1'b1;
            end
            id_load = 1'b0;
            if (!ok) begin
                fail_now("sop_wait");
                break;
            end
            if (s == 0) check("start_latency", waited, 1);
            else        check("slice_period", cyc - last_sop, PERIOD);
            last_sop = cyc;
            if (s == n - 1) start = 1'b0;
            beat = 0;
            if (s == 0) begin
                cap0 = o_payload;
                @(negedge clk);
                beat = 1;
                cap1 = o_payload;
            end
            if (glitch_beat != 0) begin
                k = (glitch_beat < 0) ? int'($urandom_range(1, 9)) : glitch_beat;
                while (beat < k) begin
                    @(negedge clk);
                    beat++;
                end
                ready = 1'b0;
                id_load = 1'b1;
                id_load_val = 15'($urandom);
                err_inj = (s == 0) && inj0;
                @(negedge clk);
                beat++;
                id_load = 1'b0;
                err_inj = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    beat++;
                end
                ready = 1'b1;
            end
            if (clr_eop && s == 0) begin
                while (beat < SLICE_LEN - 1) begin
                    @(negedge clk);
                    beat++;
                end
                cnt_clear = 1'b1;
                @(negedge clk);
                cnt_clear = 1'b0;
                check("clear_at_eop", o_tx_cnt, 0);
            end
        end

        waited = 0;
        while (o_busy && waited < 4 * PERIOD) begin
            @(negedge clk);
            waited++;
        end
        start = 1'b0;
        ready = 1'b1;
        check("return_idle", {o_busy, o_dbg_state}, 3'b000);
        check("tx_cnt", o_tx_cnt, m_cnt);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int en_seen;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_id_payload", {o_id, o_payload}, 0);
        check("reset_ctrl", {o_en, o_sop, o_eop, o_busy, o_dbg_state, o_tx_cnt}, 0);
        rst = 1'b0;
        @(negedge clk);

        // First slices from reset: IDs 0,1,2 and fixed beat payloads.
        run_slices(3, 1'b0, 15'd0, 1'b0, 0, 1'b0);
        check("first_beat0", cap0, 32'h800055D5);
        check("first_beat1", cap1, 32'hA5018000);
        check("three_done", o_tx_cnt, 3);

        // Reset asserted at beat 7 of slice ID 3.
        push_slice(m_next_id, 8);
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        check("sop_id3", {o_sop, o_id}, {1'b1, 15'd3});
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_bus", {o_en, o_sop, o_eop, o_id, o_payload}, 0);
        check("midreset_ctrl", {o_busy, o_dbg_state, o_tx_cnt}, 0);
        check("midreset_queue", exp_q.size(), 0);
        m_next_id = 15'd0;
        m_cnt = 16'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_slices(1, 1'b0, 15'd0, 1'b0, -1, 1'b0);

        // Ready low in IDLE: nothing starts.
        start = 1'b1;
        ready = 1'b0;
        en_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_en) en_seen++;
        end
        start = 1'b0;
        ready = 1'b1;
        check("ready_low_no_slice", en_seen, 0);
        // Ready dropped at beat 5: the slice still completes.
        run_slices(1, 1'b0, 15'd0, 1'b0, 5, 1'b0);

        // ID wrap: 0x7FFE, 0x7FFF, 0x0000.
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        m_cnt = 16'd0;
        check("cnt_clear_idle", o_tx_cnt, 0);
        run_slices(3, 1'b1, 15'h7FFE, 1'b0, -1, 1'b0);
        check("wrap_cnt", o_tx_cnt, 3);

        // Count to 7, then clear on the eop of the next slice.
        run_slices(4, 1'b0, 15'd0, 1'b0, 0, 1'b0);
        check("cnt_seven", o_tx_cnt, 7);
        run_slices(2, 1'b0, 15'd0, 1'b1, 0, 1'b0);

        // Error inject during slice ID 4.
        run_slices(2, 1'b1, 15'd4, 1'b0, 3, 1'b1);

        // Randomized runs.
        for (int it = 0; it < 8; it++) begin
            run_slices(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 15'($urandom),
                       1'b0, ($urandom_range(0, 1) != 0) ? -1 : 0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
